// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared widths, FSM state encoding and scan-order encoding
//               for the parallel-in/serial-out scan block.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    localparam int C_M = 4;
    localparam int C_N = 2**C_M;

    localparam bit C_LSB_FIRST = 1'b0;
    localparam bit C_MSB_FIRST = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mux_Nx1.sv
`default_nettype none
// ============================================================================
// Module      : mux_Nx1
// Description : N-to-1 bit multiplexer, y = in[sel].
// Revision    : 1.0 - initial release
// ============================================================================
module mux_Nx1
    import piso_pkg::*;
#(
    parameter int M = C_M,
    parameter int N = 2**M
) (
    input  logic [N-1:0] in,
    input  logic [M-1:0] sel,
    output logic         y
);

    assign y = in[sel];

endmodule
`default_nettype wire

// File: rtl/piso_scan.sv
`default_nettype none
// ============================================================================
// Module      : piso_scan
// Description : Parallel-in/serial-out scanner with valid/ready on both
//               sides; supports back-to-back words with no bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_scan
    import piso_pkg::*;
#(
    parameter int M         = C_M,
    parameter int N         = 2**M,
    parameter bit MSB_FIRST = C_LSB_FIRST
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_data,
    output logic         ser_out,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         ser_last,
    output logic [M-1:0] sel_out,
    output logic         busy
);

    localparam bit             c_rev   = (MSB_FIRST == C_MSB_FIRST);
    localparam logic [M-1:0]   c_first = c_rev ? M'(N - 1) : '0;
    localparam logic [M-1:0]   c_final = c_rev ? '0 : M'(N - 1);

    state_t         r_state;
    logic [M-1:0]   r_cnt;
    logic [N-1:0]   r_hold;

    logic           w_shift;
    logic           w_ser_hs;
    logic           w_load_hs;

    assign w_shift    = (r_state == SHIFT);
    assign ser_valid  = w_shift;
    assign busy       = w_shift;
    assign sel_out    = r_cnt;
    assign ser_last   = w_shift && (r_cnt == c_final);
    assign w_ser_hs   = w_shift && ser_ready;
    // Accept a new word while idle, or exactly as the final bit leaves.
    assign load_ready = !w_shift || (ser_last && ser_ready);
    assign w_load_hs  = load_valid && load_ready;

    mux_Nx1 #(
        .M (M),
        .N (N)
    ) u_mux (
        .in  (r_hold),
        .sel (r_cnt),
        .y   (ser_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
        end else if (w_load_hs) begin
            r_state <= SHIFT;
            r_cnt   <= c_first;
            r_hold  <= load_data;
        end else if (w_ser_hs) begin
            // Last bit leaves the index parked so sel_out holds in IDLE.
            if (ser_last) begin
                r_state <= IDLE;
            end else if (c_rev) begin
                r_cnt <= r_cnt - M'(1);
            end else begin
                r_cnt <= r_cnt + M'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_scan
// Description : Directed self-checking bench for piso_scan, LSB-first and
//               MSB-first instances driven in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic [15:0] load_data;
    logic        ser_ready;

    logic        ready0, out0, valid0, last0, busy0;
    logic [3:0]  sel0;
    logic        ready1, out1, valid1, last1, busy1;
    logic [3:0]  sel1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    piso_scan #(.M(4), .N(16), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (ready0),
        .load_data  (load_data),
        .ser_out    (out0),
        .ser_valid  (valid0),
        .ser_ready  (ser_ready),
        .ser_last   (last0),
        .sel_out    (sel0),
        .busy       (busy0)
    );

    piso_scan #(.M(4), .N(16), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (ready1),
        .load_data  (load_data),
        .ser_out    (out1),
        .ser_valid  (valid1),
        .ser_ready  (ser_ready),
        .ser_last   (last1),
        .sel_out    (sel1),
        .busy       (busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input bit msb, input logic [3:0] exp_sel);
        #1;
        chk("idle_valid", msb ? valid1 : valid0, 0);
        chk("idle_busy",  msb ? busy1  : busy0,  0);
        chk("idle_last",  msb ? last1  : last0,  0);
        chk("idle_ldrdy", msb ? ready1 : ready0, 1);
        chk("idle_sel",   msb ? sel1   : sel0,   exp_sel);
    endtask

    // Consume one word already loaded; stall applies ready pattern 1,0,0,1.
    task automatic serve_word(input logic [15:0] w, input bit msb, input bit stall);
        int idx;
        int n;
        int cyc;
        bit rdy;
        idx = msb ? 15 : 0;
        n   = 0;
        cyc = 0;
        while (n < 16 && cyc < 64) begin
            rdy = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            ser_ready = rdy;
            #1;
            chk("valid", msb ? valid1 : valid0, 1);
            chk("busy",  msb ? busy1  : busy0,  1);
            chk("sel",   msb ? sel1   : sel0,   idx);
            chk("bit",   msb ? out1   : out0,   w[idx]);
            chk("last",  msb ? last1  : last0,  msb ? (idx == 0) : (idx == 15));
            chk("ldrdy", msb ? ready1 : ready0, (msb ? (idx == 0) : (idx == 15)) && rdy);
            if (rdy) begin
                n++;
                idx = msb ? idx - 1 : idx + 1;
            end
            cyc++;
            tick();
        end
        chk("word_cycles", cyc, stall ? 32 : 16);
        ser_ready = 1'b1;
    endtask

    task automatic load_word(input logic [15:0] w);
        load_valid = 1'b1;
        load_data  = w;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        int          lasts;

        // Reset with a stray load request that must not be captured
        rst_n      = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        ser_ready  = 1'b1;
        tick();
        tick();
        load_valid = 1'b0;
        rst_n      = 1'b1;
        #1;
        chk("rst_out",   out0, 0);
        chk_idle(1'b0, 4'd0);
        tick();
        chk_idle(1'b0, 4'd0);
        chk("rst_msb_sel", sel1, 0);

        // LSB-first single word
        load_word(16'h0001);
        serve_word(16'h0001, 1'b0, 1'b0);
        chk_idle(1'b0, 4'd15);

        // MSB-first single word
        load_word(16'h8000);
        serve_word(16'h8000, 1'b1, 1'b0);
        chk_idle(1'b1, 4'd0);

        // Stalls must not alter the bit sequence
        load_word(16'hA5C3);
        serve_word(16'hA5C3, 1'b0, 1'b1);
        chk_idle(1'b0, 4'd15);

        // Back-to-back words with load_valid held high
        load_valid = 1'b1;
        load_data  = 16'h00FF;
        tick();
        load_data  = 16'hFF00;
        lasts      = 0;
        for (int i = 0; i < 32; i++) begin
            w = (i < 16) ? 16'h00FF : 16'hFF00;
            #1;
            chk("b2b_valid", valid0, 1);
            chk("b2b_sel",   sel0, i % 16);
            chk("b2b_bit",   out0, w[i % 16]);
            chk("b2b_ldrdy", ready0, (i % 16) == 15);
            if (last0) lasts++;
            tick();
            if (i == 15) load_valid = 1'b0;
        end
        chk("b2b_lasts", lasts, 2);
        chk_idle(1'b0, 4'd15);

        // Reset mid-word at index 7
        load_word(16'h1234);
        repeat (7) tick();
        chk("mid_sel", sel0, 7);
        rst_n = 1'b0;
        tick();
        chk("abort_valid0", valid0, 0);
        chk("abort_valid1", valid1, 0);
        rst_n = 1'b1;
        #1;
        chk("abort_out", out0, 0);
        chk_idle(1'b0, 4'd0);

        // Load request while shifting and not at the last bit is ignored
        load_word(16'h1234);
        repeat (3) tick();
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        w          = 16'h1234;
        for (int j = 3; j < 16; j++) begin
            if (j == 15) load_valid = 1'b0;
            #1;
            chk("nocap_sel",   sel0, j);
            chk("nocap_bit",   out0, w[j]);
            chk("nocap_ldrdy", ready0, j == 15);
            tick();
        end
        chk_idle(1'b0, 4'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
